// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the M pipeline register layout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Status codes
  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  // Register id meaning "no destination"
  localparam logic [3:0] REG_NONE = 4'hF;

  // M pipeline register contents
  typedef struct packed {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  stat;
  } m_reg_t;

  // A bubble is a NOP that writes nothing and reports AOK
  localparam m_reg_t M_BUBBLE = '{
    icode: I_NOP,
    cnd:   1'b0,
    val_e: 64'd0,
    val_a: 64'd0,
    dst_e: REG_NONE,
    dst_m: REG_NONE,
    stat:  S_AOK
  };

endpackage

// File: rtl/data_memory_pipelining.sv
// Byte-addressed little-endian data memory with 8-byte access and bounds check.
// Latency: read is combinational (0 cycles); write commits on the rising edge.
// Backpressure: none; an access is accepted every cycle it is presented.
module data_memory_pipelining #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              error
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  // Highest start address whose 8-byte window still fits in the array
  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

  logic [7:0]       mem [MEM_BYTES];
  logic [IDX_W-1:0] base;

  // A legal access never wraps the index, so the low address bits suffice
  assign base  = addr[IDX_W-1:0];
  // Unsigned compare also catches addresses that would wrap past 2^64
  assign error = (rd_en || wr_en) && (addr > LAST_OK);

  // Assemble 8 bytes little-endian; out-of-range or idle reads return zero
  always_comb begin
    rdata = '0;
    if (rd_en && !error) begin
      for (int i = 0; i < 8; i++) begin
        rdata[8*i +: 8] = mem[base + IDX_W'(i)];
      end
    end
  end

  // Reset zeroes the array and takes precedence over any write that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[IDX_W'(i)] <= 8'h00;
      end
    end else if (wr_en && !error) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + IDX_W'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_pipelining.sv
// Y86-64 memory stage: M pipeline register, address/control select, data memory.
// Latency: M register is 1 cycle; m_valM/m_stat are combinational from M.
// Backpressure: M_stall holds the register, M_bubble (dominant) injects a NOP.
module memory_pipelining
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  e_icode,
  input  logic        e_ConditionBit,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic [3:0]  E_stat,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat
);

  m_reg_t      m_q;
  logic [63:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        dmem_error;

  // M register: reset and bubble load a NOP, stall holds, otherwise capture E results
  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      m_q <= M_BUBBLE;
    end else if (!M_stall) begin
      m_q <= '{
        icode: e_icode,
        cnd:   e_ConditionBit,
        val_e: e_valE,
        val_a: e_valA,
        dst_e: e_dstE,
        dst_m: e_dstM,
        stat:  E_stat
      };
    end
  end

  // Stack pops read through valA (old %rsp); every other access uses valE
  always_comb begin
    mem_addr  = m_q.val_e;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (m_q.icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: mem_write = 1'b1;
      I_MRMOVQ:                  mem_read  = 1'b1;
      I_POPQ, I_RET: begin
        mem_read = 1'b1;
        mem_addr = m_q.val_a;
      end
      default: ;
    endcase
  end

  data_memory_pipelining #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .rd_en (mem_read),
    .wr_en (mem_write),
    .addr  (ADDR_W'(mem_addr)),
    .wdata (m_q.val_a),
    .rdata (m_valM),
    .error (dmem_error)
  );

  // Registered fields go straight out; a bad address overrides the carried status
  always_comb begin
    M_icode = m_q.icode;
    M_Cnd   = m_q.cnd;
    M_valE  = m_q.val_e;
    M_valA  = m_q.val_a;
    M_dstE  = m_q.dst_e;
    M_dstM  = m_q.dst_m;
    m_stat  = dmem_error ? S_ADR : m_q.stat;
  end

endmodule

// File: tb/tb_memory_pipelining.sv
// Directed bench for memory_pipelining with an expected-value queue.
// Latency: checks sample #1 after each rising edge.
// Backpressure: exercises M_stall and M_bubble explicitly.
module tb_memory_pipelining;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  e_icode;
  logic        e_ConditionBit;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [3:0]  E_stat;
  logic        M_stall;
  logic        M_bubble;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [3:0]  m_stat;

  memory_pipelining #(.MEM_BYTES(MB), .ADDR_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .e_icode        (e_icode),
    .e_ConditionBit (e_ConditionBit),
    .e_valE         (e_valE),
    .e_valA         (e_valA),
    .e_dstE         (e_dstE),
    .e_dstM         (e_dstM),
    .E_stat         (E_stat),
    .M_stall        (M_stall),
    .M_bubble       (M_bubble),
    .M_icode        (M_icode),
    .M_Cnd          (M_Cnd),
    .M_valE         (M_valE),
    .M_valA         (M_valA),
    .M_dstE         (M_dstE),
    .M_dstM         (M_dstM),
    .m_valM         (m_valM),
    .m_stat         (m_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic expect_val(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h required=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) pass_cnt++;
      else $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
    end
  endtask

  // Drive one E-stage result, clock it into M, and settle for sampling
  task automatic step(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                      input logic [3:0] de, input logic [3:0] dm, input logic [3:0] st);
    e_icode        = ic;
    e_ConditionBit = 1'b1;
    e_valE         = ve;
    e_valA         = va;
    e_dstE         = de;
    e_dstM         = dm;
    E_stat         = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    M_stall = 1'b0;
    M_bubble = 1'b0;
    e_icode = 4'h0;
    e_ConditionBit = 1'b1;
    e_valE = 64'hDEAD;
    e_valA = 64'hBEEF;
    e_dstE = 4'h2;
    e_dstM = 4'h3;
    E_stat = 4'h1;

    // Reset: M holds the bubble
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_val("rst_icode", 64'h1);  check(64'(M_icode));
    expect_val("rst_cnd",   64'h0);  check(64'(M_Cnd));
    expect_val("rst_valE",  64'h0);  check(M_valE);
    expect_val("rst_valA",  64'h0);  check(M_valA);
    expect_val("rst_dstE",  64'hF);  check(64'(M_dstE));
    expect_val("rst_dstM",  64'hF);  check(64'(M_dstM));
    expect_val("rst_stat",  64'h1);  check(64'(m_stat));
    expect_val("rst_valM",  64'h0);  check(m_valM);
    rst = 1'b0;

    // Read of address 0 after reset
    step(4'h5, 64'h0, 64'h0, 4'hF, 4'h1, 4'h1);
    expect_val("rd0_valM", 64'h0);  check(m_valM);

    // Store then load at 0x10
    step(4'h4, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 4'h1);
    expect_val("st10_stat", 64'h1);  check(64'(m_stat));
    expect_val("st10_valM", 64'h0);  check(m_valM);
    step(4'h5, 64'h10, 64'h0, 4'hF, 4'h3, 4'h1);
    expect_val("ld10_valM", 64'h1122334455667788);  check(m_valM);
    expect_val("ld10_dstM", 64'h3);                 check(64'(M_dstM));
    // Unaligned read: byte at 0x10 lands in the top byte
    step(4'h5, 64'h09, 64'h0, 4'hF, 4'h3, 4'h1);
    expect_val("ld09_valM", 64'h8800000000000000);  check(m_valM);

    // POPQ reads from valA, passes valE through
    step(4'h4, 64'h20, 64'hAAAA0000AAAA0000, 4'hF, 4'hF, 4'h1);
    step(4'h4, 64'h28, 64'hBBBB0000BBBB0000, 4'hF, 4'hF, 4'h1);
    step(4'hB, 64'h28, 64'h20, 4'h4, 4'h5, 4'h1);
    expect_val("pop_valM", 64'hAAAA0000AAAA0000);  check(m_valM);
    expect_val("pop_valE", 64'h28);                check(M_valE);

    // Out-of-range push must not touch the last legal window
    step(4'h4, 64'(MB - 8), 64'h0102030405060708, 4'hF, 4'hF, 4'h1);
    step(4'hA, 64'(MB - 7), 64'hFFFFFFFFFFFFFFFF, 4'h4, 4'hF, 4'h1);
    expect_val("push_oob_stat", 64'h3);  check(64'(m_stat));
    step(4'h5, 64'(MB - 8), 64'h0, 4'hF, 4'h1, 4'h1);
    expect_val("ld_last_stat", 64'h1);                 check(64'(m_stat));
    expect_val("ld_last_valM", 64'h0102030405060708);  check(m_valM);
    step(4'h5, 64'hFFFFFFFFFFFFFFF8, 64'h0, 4'hF, 4'h1, 4'h1);
    expect_val("ld_wrap_stat", 64'h3);  check(64'(m_stat));
    expect_val("ld_wrap_valM", 64'h0);  check(m_valM);

    // Stall holds M while E changes, then bubble beats stall
    step(4'h5, 64'h10, 64'h0, 4'hF, 4'h5, 4'h1);
    expect_val("pre_stall_valM", 64'h1122334455667788);  check(m_valM);
    M_stall = 1'b1;
    step(4'h4, 64'h99, 64'h77, 4'h6, 4'h7, 4'h2);
    expect_val("stall1_icode", 64'h5);   check(64'(M_icode));
    expect_val("stall1_valE",  64'h10);  check(M_valE);
    step(4'hA, 64'h55, 64'h66, 4'h8, 4'h9, 4'h4);
    expect_val("stall2_dstM",  64'h5);   check(64'(M_dstM));
    expect_val("stall2_valA",  64'h0);   check(M_valA);
    M_bubble = 1'b1;
    step(4'hA, 64'h55, 64'h66, 4'h8, 4'h9, 4'h4);
    expect_val("bub_icode", 64'h1);  check(64'(M_icode));
    expect_val("bub_dstM",  64'hF);  check(64'(M_dstM));
    expect_val("bub_valE",  64'h0);  check(M_valE);
    M_stall = 1'b0;
    M_bubble = 1'b0;

    // HLT status passes through a NOP
    step(4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 4'h2);
    expect_val("hlt_stat", 64'h2);  check(64'(m_stat));

    // Reset during a CALL write cycle
    step(4'h8, 64'h40, 64'h5555AAAA5555AAAA, 4'h4, 4'hF, 4'h1);
    expect_val("call_stat", 64'h1);  check(64'(m_stat));
    rst = 1'b1;
    step(4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 4'h1);
    expect_val("rstcall_icode", 64'h1);  check(64'(M_icode));
    expect_val("rstcall_valA",  64'h0);  check(M_valA);
    rst = 1'b0;
    step(4'h5, 64'h40, 64'h0, 4'hF, 4'h1, 4'h1);
    expect_val("rstcall_mem40", 64'h0);  check(m_valM);
    step(4'h5, 64'h10, 64'h0, 4'hF, 4'h1, 4'h1);
    expect_val("rstcall_mem10", 64'h0);  check(m_valM);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
